// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port synchronous SRAM between the instruction-fetch
// requester (read-only) and the data requester (read/write, byte enables).
// Each requester holds req until its done pulse. At most one SRAM access is
// issued per cycle, and the response returns on the following cycle.
// Optional feature: define ARB_ROUND_ROBIN_EN to arbitrate contention
// round-robin. When it is undefined, data always wins on contention.
module sram_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_done,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic [DW/8-1:0] d_wen,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_done,
  output logic [DW-1:0]   d_rdata,
  output logic            sram_en,
  output logic [DW/8-1:0] sram_wen,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata
);

  // state    | meaning
  // ST_IDLE  | no response due this cycle
  // ST_RSP_I | fetch response due this cycle (i_done)
  // ST_RSP_D | data response due this cycle (d_done)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RSP_I = 2'd1,
    ST_RSP_D = 2'd2
  } state_t;

  state_t r_state;
  logic   r_i_done;
  logic   r_d_done;

  logic   w_i_elig;
  logic   w_d_elig;
  logic   w_gnt_i;
  logic   w_gnt_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic   r_rr_data;  // 1: data wins the next contended grant
  logic   w_contend;
`endif

  // A requester whose response is returning this cycle is completing, not
  // asking again. Reset blocks all grants.
  always_comb begin
    w_i_elig = !rst && i_req && (r_state != ST_RSP_I);
    w_d_elig = !rst && d_req && (r_state != ST_RSP_D);
  end

  // Pick the winner for this cycle's SRAM slot.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    w_contend = w_i_elig && w_d_elig;
    w_gnt_d   = w_d_elig && (!w_i_elig || r_rr_data);
`else
    w_gnt_d   = w_d_elig;
`endif
    w_gnt_i   = w_i_elig && !w_gnt_d;
  end

  // Drive the SRAM from the winner. An idle slot drives all zeros.
  always_comb begin
    sram_en    = w_gnt_i || w_gnt_d;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_gnt_d) begin
      sram_wen   = d_wen;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end else if (w_gnt_i) begin
      sram_addr  = i_addr;
    end
  end

  // Response FSM: remember which requester owns the data returning next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else begin
      if (w_gnt_d) begin
        r_state <= ST_RSP_D;
      end else if (w_gnt_i) begin
        r_state <= ST_RSP_I;
      end else begin
        r_state <= ST_IDLE;
      end
      r_i_done <= w_gnt_i;
      r_d_done <= w_gnt_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin pointer. It moves only when both requesters competed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_data <= 1'b1;
    end else if (w_contend) begin
      r_rr_data <= w_gnt_i;
    end
  end
`endif

  // Reset discards a returning response, so done stays low during reset.
  always_comb begin
    i_done  = r_i_done && !rst;
    d_done  = r_d_done && !rst;
    i_rdata = i_done ? sram_rdata : '0;
    d_rdata = d_done ? sram_rdata : '0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
`timescale 1ns/1ps
module tb_sram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int W_NONE = 0;
  localparam int W_I = 1;
  localparam int W_D = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic [BW-1:0] d_wen;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          sram_en;
  logic [BW-1:0] sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.AW(AW), .DW(DW)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural single-port SRAM, 8 words. It returns the old contents on a write.
  logic [DW-1:0] sram_mem [8] = '{32'h3C1D8000, 32'h11111111, 32'h22222222, 32'h33333333,
                                  32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= sram_mem[sram_addr[4:2]];
      for (int b = 0; b < BW; b++)
        if (sram_wen[b]) sram_mem[sram_addr[4:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  // Reference model: who owns the pending response, who won the last contention,
  // and a golden copy of memory.
  logic [DW-1:0] gold [8] = '{32'h3C1D8000, 32'h11111111, 32'h22222222, 32'h33333333,
                              32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
  int            m_pend = W_NONE;
  int            m_last = W_I;
  int            m_win;
  logic [DW-1:0] m_data = '0;
  logic          m_idone, m_ddone, m_ei, m_ed;
  int            i_wait = 0;
  int            d_wait = 0;

  always @(negedge clk) begin
    m_idone = !rst && (m_pend == W_I);
    m_ddone = !rst && (m_pend == W_D);
    chk("i_done", i_done, m_idone);
    chk("d_done", d_done, m_ddone);
    chk("i_rdata", i_rdata, m_idone ? m_data : '0);
    chk("d_rdata", d_rdata, m_ddone ? m_data : '0);
    chk("never_both_done", i_done && d_done, 1'b0);

    m_ei = !rst && i_req && (m_pend != W_I);
    m_ed = !rst && d_req && (m_pend != W_D);
    if (m_ei && m_ed) begin
`ifdef ARB_ROUND_ROBIN_EN
      m_win = (m_last == W_D) ? W_I : W_D;
`else
      m_win = W_D;
`endif
    end else if (m_ei) m_win = W_I;
    else if (m_ed) m_win = W_D;
    else m_win = W_NONE;

    chk("sram_en", sram_en, m_win != W_NONE);
    chk("sram_wen", sram_wen, (m_win == W_D) ? d_wen : '0);
    chk("sram_addr", sram_addr, (m_win == W_I) ? i_addr : (m_win == W_D) ? d_addr : '0);
    chk("sram_wdata", sram_wdata, (m_win == W_D) ? d_wdata : '0);

    if (rst) begin
      i_wait = 0;
      d_wait = 0;
    end else begin
      if (i_req) i_wait++;
      if (d_req) d_wait++;
      if (m_idone) begin chk("i_latency", i_wait <= 3, 1'b1); i_wait = 0; end
      if (m_ddone) begin chk("d_latency", d_wait <= 3, 1'b1); d_wait = 0; end
    end

    if (rst) begin
      m_pend = W_NONE;
      m_last = W_I;
    end else begin
      if (m_ei && m_ed) m_last = m_win;
      m_pend = m_win;
      if (m_win == W_I) m_data = gold[i_addr[4:2]];
      if (m_win == W_D) begin
        m_data = gold[d_addr[4:2]];
        for (int b = 0; b < BW; b++)
          if (d_wen[b]) gold[d_addr[4:2]][8*b +: 8] = d_wdata[8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop each request after its done pulse until both requesters are quiet.
  task automatic drain();
    logic di, dd;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      di = i_done;
      dd = d_done;
      tick();
      if (di) i_req = 1'b0;
      if (dd) d_req = 1'b0;
    end
  endtask

  initial begin
    logic          di, dd;
    logic [31:0]   r;
    logic [AW-1:0] exp_addr;
    int            i_hold, d_hold;

    // Reset with both requests high. Data wins the first grant.
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_wen = '0;
    d_addr = 32'h8; d_wdata = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t1_rst_en", sram_en, 1'b0);
      chk("t1_rst_idone", i_done, 1'b0);
      chk("t1_rst_ddone", d_done, 1'b0);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("t1_first_en", sram_en, 1'b1);
    chk("t1_first_is_d", sram_addr, 32'h8);
    tick();
    @(negedge clk);
    chk("t1_d_done", d_done, 1'b1);
    chk("t1_then_i", sram_addr, 32'h4);
    tick(); d_req = 1'b0;
    @(negedge clk);
    chk("t1_i_done", i_done, 1'b1);
    tick(); i_req = 1'b0;
    tick();

    // Lone fetch.
    i_req = 1'b1; i_addr = 32'hBFC00000;
    @(negedge clk);
    chk("t2_en", sram_en, 1'b1);
    chk("t2_wen", sram_wen, 4'b0000);
    chk("t2_addr", sram_addr, 32'hBFC00000);
    tick();
    @(negedge clk);
    chk("t2_done", i_done, 1'b1);
    chk("t2_rdata", i_rdata, 32'h3C1D8000);
    tick(); i_req = 1'b0;

    // Partial data write.
    d_req = 1'b1; d_wen = 4'b0011; d_addr = 32'h80001000; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t3_wen", sram_wen, 4'b0011);
    chk("t3_wdata", sram_wdata, 32'hDEADBEEF);
    chk("t3_addr", sram_addr, 32'h80001000);
    tick();
    @(negedge clk);
    chk("t3_d_done", d_done, 1'b1);
    chk("t3_i_done", i_done, 1'b0);
    tick(); d_req = 1'b0; d_wen = '0;

    // Sustained contention: grants alternate and the SRAM is busy every cycle.
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h14;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      exp_addr = (c % 2 == 0) ? 32'h10 : 32'h14;
`else
      exp_addr = (c % 2 == 0) ? 32'h14 : 32'h10;
`endif
      chk("t4_en", sram_en, 1'b1);
      chk("t4_order", sram_addr, exp_addr);
      tick();
    end
    drain();

    // Reset while a fetch response is due.
    i_req = 1'b1; i_addr = 32'h18;
    @(negedge clk);
    chk("t6_grant", sram_en, 1'b1);
    tick(); rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    chk("t6_rst_idone", i_done, 1'b0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t6_after_idone", i_done, 1'b0);
    chk("t6_after_en", sram_en, 1'b0);
    tick();

    // Random traffic, with occasional resets.
    i_hold = 0; d_hold = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      di = i_done;
      dd = d_done;
      tick();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_hold = 0; d_hold = 0;
      end
      if (!rst) begin
        if (di) begin i_req = 1'b0; i_hold = 0; end
        if (dd) begin d_req = 1'b0; d_hold = 0; end
        if (i_req) begin
          i_hold++;
          if (i_hold > 6) begin chk("i_stuck", di, 1'b1); i_req = 1'b0; i_hold = 0; end
        end
        if (d_req) begin
          d_hold++;
          if (d_hold > 6) begin chk("d_stuck", dd, 1'b1); d_req = 1'b0; d_hold = 0; end
        end
        if (!i_req && $urandom_range(0, 3) != 0) begin
          r = $urandom();
          i_req = 1'b1;
          i_addr = {r[31:5], 3'($urandom_range(0, 7)), 2'b00};
        end
        if (!d_req && $urandom_range(0, 3) != 0) begin
          r = $urandom();
          d_req = 1'b1;
          d_addr = {r[31:5], 3'($urandom_range(0, 7)), 2'b00};
          d_wen = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
          d_wdata = $urandom();
        end
      end
    end
    rst = 1'b0;
    drain();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
